// File: rtl/sched_pkg.sv
// Shared types and defaults for the DSP frame scheduler.
// Build option: SCHED_STATS_EN adds frame/drop statistics counters to dsp_frame_sched.
package sched_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_CFG_W   = 4;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND_L = 3'd1,
      WAIT_L = 3'd2,
      SEND_R = 3'd3,
      WAIT_R = 3'd4,
      COMMIT = 3'd5
   } sched_state_e;

   typedef enum logic {
      CHAN_L = 1'b0,
      CHAN_R = 1'b1
   } chan_e;

endpackage

// File: rtl/dsp_watchdog.sv
// Per-channel stall watchdog: counts cycles while enabled and flags expiry
// on the TIMEOUT-th cycle after a clear, so one channel never takes longer
// than TIMEOUT cycles.
module dsp_watchdog
   import sched_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Count from zero after each clear and park at the terminal value
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = enable && (count == LAST);

endmodule

// File: rtl/dsp_frame_sched.sv
// Time-shares one DSP between the left and right channel of each stereo
// frame, latching the user settings once per frame and bypassing the DSP
// with the raw sample when it stalls.
// Build option: SCHED_STATS_EN adds frames_o and drops_o counters.
module dsp_frame_sched
   import sched_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CFG_W   = DEF_CFG_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             sclk_i,
   input  logic             rst_i,
   input  logic             rx_valid_i,
   input  logic [WIDTH-1:0] rx_left_i,
   input  logic [WIDTH-1:0] rx_right_i,
   input  logic [CFG_W-1:0] reqSetting_i,
   input  logic [CFG_W-1:0] freqSetting_i,
   output logic             dsp_valid_o,
   input  logic             dsp_ready_i,
   output logic [WIDTH-1:0] dsp_data_o,
   output logic             dsp_chan_o,
   output logic [CFG_W-1:0] dsp_req_o,
   output logic [CFG_W-1:0] dsp_freq_o,
   input  logic             dsp_rvalid_i,
   input  logic [WIDTH-1:0] dsp_rdata_i,
   output logic [WIDTH-1:0] tx_left_o,
   output logic [WIDTH-1:0] tx_right_o,
   output logic             tx_load_o,
   output logic             busy_o,
   output logic             overrun_o,
   output logic             timeout_o,
   input  logic             clr_status_i
`ifdef SCHED_STATS_EN
   ,
   output logic [15:0]      frames_o,
   output logic [15:0]      drops_o
`endif
);

   localparam logic [2:0] ST_IDLE   = 3'(IDLE);
   localparam logic [2:0] ST_SEND_L = 3'(SEND_L);
   localparam logic [2:0] ST_WAIT_L = 3'(WAIT_L);
   localparam logic [2:0] ST_SEND_R = 3'(SEND_R);
   localparam logic [2:0] ST_WAIT_R = 3'(WAIT_R);
   localparam logic [2:0] ST_COMMIT = 3'(COMMIT);

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic [WIDTH-1:0] left_s;
   logic [WIDTH-1:0] right_s;
   logic [CFG_W-1:0] req_s;
   logic [CFG_W-1:0] freq_s;
   logic [WIDTH-1:0] res_l;
   logic [WIDTH-1:0] tx_left;
   logic [WIDTH-1:0] tx_right;
   logic             overrun;
   logic             timeout;

   logic             in_send;
   logic             in_wait;
   logic             in_chan;
   logic             is_right;
   logic             start_frame;
   logic             drop_frame;
   logic             result_ok;
   logic             bypass;
   logic             chan_done;
   logic             wd_clear;
   logic             wd_expire;
   logic [WIDTH-1:0] raw_sample;
   logic [WIDTH-1:0] chan_result;

   assign in_send     = (state == ST_SEND_L) || (state == ST_SEND_R);
   assign in_wait     = (state == ST_WAIT_L) || (state == ST_WAIT_R);
   assign in_chan     = in_send || in_wait;
   assign is_right    = (state == ST_SEND_R) || (state == ST_WAIT_R);
   assign start_frame = rx_valid_i && ((state == ST_IDLE) || (state == ST_COMMIT));
   assign drop_frame  = rx_valid_i && in_chan;
   assign result_ok   = in_wait && dsp_rvalid_i;
   assign bypass      = in_chan && wd_expire && !result_ok;
   assign chan_done   = result_ok || bypass;
   assign raw_sample  = is_right ? right_s : left_s;
   assign chan_result = result_ok ? dsp_rdata_i : raw_sample;

   // Next-state selection; a watchdog bypass advances exactly like a result
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:   if (rx_valid_i) state_next = ST_SEND_L;
         ST_SEND_L: if (bypass) state_next = ST_SEND_R;
                    else if (dsp_ready_i) state_next = ST_WAIT_L;
         ST_WAIT_L: if (chan_done) state_next = ST_SEND_R;
         ST_SEND_R: if (bypass) state_next = ST_COMMIT;
                    else if (dsp_ready_i) state_next = ST_WAIT_R;
         ST_WAIT_R: if (chan_done) state_next = ST_COMMIT;
         ST_COMMIT: state_next = rx_valid_i ? ST_SEND_L : ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   assign wd_clear = ((state_next == ST_SEND_L) || (state_next == ST_SEND_R)) &&
                     (state_next != state);

   dsp_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (sclk_i),
      .rst    (rst_i),
      .clear  (wd_clear),
      .enable (in_chan),
      .expire (wd_expire)
   );

   // State register
   always_ff @(posedge sclk_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Frame shadow: samples and settings are captured only when a frame is accepted
   always_ff @(posedge sclk_i) begin
      if (rst_i) begin
         left_s  <= '0;
         right_s <= '0;
         req_s   <= '0;
         freq_s  <= '0;
      end else if (start_frame) begin
         left_s  <= rx_left_i;
         right_s <= rx_right_i;
         req_s   <= reqSetting_i;
         freq_s  <= freqSetting_i;
      end
   end

   // Hold the left result, then publish both results together as the frame completes
   always_ff @(posedge sclk_i) begin
      if (rst_i) begin
         res_l    <= '0;
         tx_left  <= '0;
         tx_right <= '0;
      end else if (chan_done) begin
         if (is_right) begin
            tx_left  <= res_l;
            tx_right <= chan_result;
         end else begin
            res_l <= chan_result;
         end
      end
   end

   // Sticky status flags; a new event in the clear cycle keeps the flag set
   always_ff @(posedge sclk_i) begin
      if (rst_i) begin
         overrun <= 1'b0;
         timeout <= 1'b0;
      end else begin
         if (drop_frame)        overrun <= 1'b1;
         else if (clr_status_i) overrun <= 1'b0;
         if (bypass)            timeout <= 1'b1;
         else if (clr_status_i) timeout <= 1'b0;
      end
   end

`ifdef SCHED_STATS_EN
   logic [15:0] frames;
   logic [15:0] drops;

   // Free-running statistics, untouched by the status clear
   always_ff @(posedge sclk_i) begin
      if (rst_i) begin
         frames <= '0;
         drops  <= '0;
      end else begin
         if (state == ST_COMMIT) frames <= frames + 16'd1;
         if (drop_frame)         drops  <= drops + 16'd1;
      end
   end

   assign frames_o = frames;
   assign drops_o  = drops;
`endif

   assign dsp_valid_o = in_send;
   assign dsp_data_o  = raw_sample;
   assign dsp_chan_o  = is_right ? CHAN_R : CHAN_L;
   assign dsp_req_o   = req_s;
   assign dsp_freq_o  = freq_s;
   assign tx_left_o   = tx_left;
   assign tx_right_o  = tx_right;
   assign tx_load_o   = (state == ST_COMMIT);
   assign busy_o      = (state != ST_IDLE);
   assign overrun_o   = overrun;
   assign timeout_o   = timeout;

endmodule

// File: tb/tb_dsp_frame_sched.sv
// Directed and randomized checks of dsp_frame_sched against a frame-level
// reference model (results, commit latency, status flags).
// Build option: SCHED_STATS_EN also checks frames_o and drops_o.
module tb_dsp_frame_sched;

   localparam int WIDTH   = 16;
   localparam int CFG_W   = 4;
   localparam int TIMEOUT = 64;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             rx_valid_i;
   logic [WIDTH-1:0] rx_left_i;
   logic [WIDTH-1:0] rx_right_i;
   logic [CFG_W-1:0] reqSetting_i;
   logic [CFG_W-1:0] freqSetting_i;
   logic             dsp_valid_o;
   logic             dsp_ready_i;
   logic [WIDTH-1:0] dsp_data_o;
   logic             dsp_chan_o;
   logic [CFG_W-1:0] dsp_req_o;
   logic [CFG_W-1:0] dsp_freq_o;
   logic             dsp_rvalid_i;
   logic [WIDTH-1:0] dsp_rdata_i;
   logic [WIDTH-1:0] tx_left_o;
   logic [WIDTH-1:0] tx_right_o;
   logic             tx_load_o;
   logic             busy_o;
   logic             overrun_o;
   logic             timeout_o;
   logic             clr_status_i;
`ifdef SCHED_STATS_EN
   logic [15:0]      frames_o;
   logic [15:0]      drops_o;
`endif

   int checks = 0;
   int errors = 0;

   int dly_l  = 1;
   int dly_r  = 1;
   bit mute_r = 1'b0;
   int resp_cnt = 0;
   logic [WIDTH-1:0] resp_data = '0;

   dsp_frame_sched #(
      .WIDTH   (WIDTH),
      .CFG_W   (CFG_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sclk_i        (clk),
      .rst_i         (rst_i),
      .rx_valid_i    (rx_valid_i),
      .rx_left_i     (rx_left_i),
      .rx_right_i    (rx_right_i),
      .reqSetting_i  (reqSetting_i),
      .freqSetting_i (freqSetting_i),
      .dsp_valid_o   (dsp_valid_o),
      .dsp_ready_i   (dsp_ready_i),
      .dsp_data_o    (dsp_data_o),
      .dsp_chan_o    (dsp_chan_o),
      .dsp_req_o     (dsp_req_o),
      .dsp_freq_o    (dsp_freq_o),
      .dsp_rvalid_i  (dsp_rvalid_i),
      .dsp_rdata_i   (dsp_rdata_i),
      .tx_left_o     (tx_left_o),
      .tx_right_o    (tx_right_o),
      .tx_load_o     (tx_load_o),
      .busy_o        (busy_o),
      .overrun_o     (overrun_o),
      .timeout_o     (timeout_o),
`ifdef SCHED_STATS_EN
      .frames_o      (frames_o),
      .drops_o       (drops_o),
`endif
      .clr_status_i  (clr_status_i)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Behavioural DSP: answers each accepted request with data+1 after a per-channel delay
   initial begin
      dsp_rvalid_i = 1'b0;
      dsp_rdata_i  = '0;
      forever begin
         @(negedge clk);
         #1;
         dsp_rvalid_i = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               dsp_rvalid_i = 1'b1;
               dsp_rdata_i  = resp_data + 16'd1;
            end
         end
         if (dsp_valid_o && dsp_ready_i && resp_cnt == 0 && !(mute_r && dsp_chan_o)) begin
            resp_cnt  = dsp_chan_o ? dly_r : dly_l;
            resp_data = dsp_data_o;
         end
      end
   end

   // Global guard so a stuck design can never hang the run
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 2000000");
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one frame for a single cycle; returns at cycle 1 of the frame
   task automatic applyStimulus(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                                input logic [CFG_W-1:0] req, input logic [CFG_W-1:0] freq);
      rx_valid_i    = 1'b1;
      rx_left_i     = l;
      rx_right_i    = r;
      reqSetting_i  = req;
      freqSetting_i = freq;
      @(negedge clk);
      rx_valid_i = 1'b0;
   endtask

   task automatic waitLoad(input int limit, output int cycles);
      cycles = 0;
      while (tx_load_o !== 1'b1 && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   // Reference: cycles one channel occupies (accept wait + request + result, or the full watchdog window)
   function automatic int chanDur(input int hold, input int dly, input bit responds);
      if (!responds || (hold + dly + 1) > TIMEOUT) return TIMEOUT;
      return hold + dly + 1;
   endfunction

   function automatic logic [WIDTH-1:0] chanResult(input logic [WIDTH-1:0] s, input bit responds);
      return responds ? s + 16'd1 : s;
   endfunction

   initial begin
      logic [WIDTH-1:0] l, r, l2, r2;
      int cyc;
      int dl, dr;
      bit saw_load;

      rst_i = 1'b1; rx_valid_i = 1'b0; rx_left_i = '0; rx_right_i = '0;
      reqSetting_i = '0; freqSetting_i = '0; dsp_ready_i = 1'b1; clr_status_i = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rst_tx_left", tx_left_o, 0);
      checkOutput("rst_tx_right", tx_right_o, 0);
      checkOutput("rst_tx_load", tx_load_o, 0);
      checkOutput("rst_dsp_valid", dsp_valid_o, 0);
      checkOutput("rst_dsp_data", dsp_data_o, 0);
      checkOutput("rst_dsp_cfg", {dsp_req_o, dsp_freq_o}, 0);
      checkOutput("rst_flags", {busy_o, overrun_o, timeout_o, dsp_chan_o}, 0);
`ifdef SCHED_STATS_EN
      checkOutput("rst_stats", {frames_o, drops_o}, 0);
`endif
      rst_i = 1'b0;
      repeat (2) @(negedge clk);

      // Basic frame, immediate DSP
      $display("[TB] basic frame");
      applyStimulus(16'h1234, 16'hABCD, 4'd3, 4'd5);
      checkOutput("c1_valid", dsp_valid_o, 1);
      checkOutput("c1_data", dsp_data_o, 16'h1234);
      checkOutput("c1_chan", dsp_chan_o, 0);
      checkOutput("c1_cfg", {dsp_req_o, dsp_freq_o}, {4'd3, 4'd5});
      checkOutput("c1_busy", busy_o, 1);
      waitLoad(20, cyc);
      checkOutput("basic_load_cycle", 1 + cyc, 1 + chanDur(0, 1, 1) + chanDur(0, 1, 1));
      checkOutput("basic_tx_left", tx_left_o, 16'h1235);
      checkOutput("basic_tx_right", tx_right_o, 16'hABCE);
      @(negedge clk);
      checkOutput("basic_load_pulse", {tx_load_o, busy_o}, 0);

      // Ready held low 10 cycles
      $display("[TB] ready stall");
      l = 16'($urandom); r = 16'($urandom);
      dsp_ready_i = 1'b0;
      applyStimulus(l, r, 4'd1, 4'd2);
      for (int k = 0; k < 10; k++) begin
         checkOutput("hold_stable", {dsp_valid_o, dsp_chan_o, dsp_data_o}, {1'b1, 1'b0, l});
         @(negedge clk);
      end
      dsp_ready_i = 1'b1;
      waitLoad(40, cyc);
      checkOutput("hold_load_cycle", 11 + cyc, 1 + chanDur(10, 1, 1) + chanDur(0, 1, 1));
      checkOutput("hold_tx", {tx_left_o, tx_right_o}, {chanResult(l, 1), chanResult(r, 1)});
      @(negedge clk);

      // Settings change mid-frame
      $display("[TB] settings latch");
      l = 16'($urandom); r = 16'($urandom);
      applyStimulus(l, r, 4'd3, 4'd7);
      reqSetting_i = 4'd9;
      cyc = 0;
      while (!(dsp_valid_o && dsp_chan_o) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("cfg_r_request", {dsp_valid_o, dsp_chan_o, dsp_req_o}, {1'b1, 1'b1, 4'd3});
      waitLoad(20, cyc);
      checkOutput("cfg_frame_load", tx_load_o, 1);
      @(negedge clk);
      applyStimulus(l, r, reqSetting_i, 4'd7);
      checkOutput("cfg_next_frame", dsp_req_o, 4'd9);
      waitLoad(20, cyc);
      @(negedge clk);

      // DSP never answers the right channel
      $display("[TB] watchdog bypass");
      checkOutput("to_clear_before", timeout_o, 0);
      l = 16'($urandom); r = 16'($urandom);
      mute_r = 1'b1;
      applyStimulus(l, r, 4'd2, 4'd2);
      waitLoad(200, cyc);
      checkOutput("to_load_cycle", 1 + cyc, 1 + chanDur(0, 1, 1) + chanDur(0, 0, 0));
      checkOutput("to_tx", {tx_left_o, tx_right_o}, {chanResult(l, 1), chanResult(r, 0)});
      checkOutput("to_flag", timeout_o, 1);
      mute_r = 1'b0;
      @(negedge clk);
      clr_status_i = 1'b1;
      @(negedge clk);
      clr_status_i = 1'b0;
      checkOutput("to_cleared", timeout_o, 0);

      // Result arriving exactly at the watchdog limit wins
      $display("[TB] watchdog boundary");
      l = 16'($urandom); r = 16'($urandom);
      dly_r = TIMEOUT - 1;
      applyStimulus(l, r, 4'd2, 4'd2);
      waitLoad(200, cyc);
      checkOutput("edge_load_cycle", 1 + cyc, 1 + chanDur(0, 1, 1) + chanDur(0, TIMEOUT - 1, 1));
      checkOutput("edge_tx_right", tx_right_o, chanResult(r, 1));
      checkOutput("edge_no_timeout", timeout_o, 0);
      dly_r = 1;
      @(negedge clk);

      // Frame arriving while the left channel is in flight
      $display("[TB] overrun");
      checkOutput("ovr_clear_before", overrun_o, 0);
      l = 16'($urandom); r = 16'($urandom);
      dly_l = 5;
      applyStimulus(l, r, 4'd4, 4'd4);
      @(negedge clk);
      @(negedge clk);
      rx_valid_i = 1'b1; rx_left_i = ~l; rx_right_i = ~r; reqSetting_i = 4'd15;
      @(negedge clk);
      rx_valid_i = 1'b0;
      checkOutput("ovr_flag", overrun_o, 1);
      waitLoad(40, cyc);
      checkOutput("ovr_load_cycle", 4 + cyc, 1 + chanDur(0, 5, 1) + chanDur(0, 1, 1));
      checkOutput("ovr_tx", {tx_left_o, tx_right_o}, {chanResult(l, 1), chanResult(r, 1)});
`ifdef SCHED_STATS_EN
      checkOutput("ovr_drops", drops_o, 1);
`endif
      dly_l = 1;
      @(negedge clk);
      clr_status_i = 1'b1;
      @(negedge clk);
      clr_status_i = 1'b0;
      checkOutput("ovr_cleared", overrun_o, 0);

      // New frame in the commit cycle
      $display("[TB] back-to-back");
      l = 16'($urandom); r = 16'($urandom);
      l2 = 16'($urandom); r2 = 16'($urandom);
      applyStimulus(l, r, 4'd1, 4'd1);
      waitLoad(20, cyc);
      checkOutput("b2b_first_tx", {tx_left_o, tx_right_o}, {chanResult(l, 1), chanResult(r, 1)});
      applyStimulus(l2, r2, 4'd6, 4'd6);
      checkOutput("b2b_restart", {dsp_valid_o, dsp_chan_o, dsp_data_o}, {1'b1, 1'b0, l2});
      checkOutput("b2b_no_overrun", overrun_o, 0);
      waitLoad(20, cyc);
      checkOutput("b2b_load_cycle", 1 + cyc, 1 + chanDur(0, 1, 1) + chanDur(0, 1, 1));
      checkOutput("b2b_second_tx", {tx_left_o, tx_right_o}, {chanResult(l2, 1), chanResult(r2, 1)});
      @(negedge clk);

      // Reset while the right channel is pending
      $display("[TB] reset mid-frame");
      applyStimulus(16'($urandom), 16'($urandom), 4'd2, 4'd3);
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      checkOutput("mid_rst_state", {busy_o, tx_load_o, tx_left_o, tx_right_o}, 0);
      saw_load = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (tx_load_o) saw_load = 1'b1;
      end
      checkOutput("mid_rst_no_load", saw_load, 0);

      // Randomized frames with random DSP latency
      $display("[TB] random frames");
      for (int i = 0; i < 6; i++) begin
         l = 16'($urandom); r = 16'($urandom);
         dl = $urandom_range(1, 4); dr = $urandom_range(1, 4);
         dly_l = dl; dly_r = dr;
         applyStimulus(l, r, 4'($urandom), 4'($urandom));
         waitLoad(60, cyc);
         checkOutput("rnd_load_cycle", 1 + cyc, 1 + chanDur(0, dl, 1) + chanDur(0, dr, 1));
         checkOutput("rnd_tx", {tx_left_o, tx_right_o}, {chanResult(l, 1), chanResult(r, 1)});
         @(negedge clk);
      end
`ifdef SCHED_STATS_EN
      checkOutput("stats_after_rnd", {frames_o, drops_o}, {16'd6, 16'd0});
`endif
      checkOutput("final_flags", {overrun_o, timeout_o, busy_o}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
